// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary NxN systolic matrix-multiply engine
module systolic_mm_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int K_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    input  logic                  signed_mode,
    input  logic                  sat_en,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [N*DATA_W-1:0]   a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [N*DATA_W-1:0]   b_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [N*ACC_W-1:0]    r_data,
    output logic [$clog2(N)-1:0]  r_row,
    output logic                  r_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [31:0]           cycle_count,
    output logic [31:0]           mac_count
);
    localparam int RW = $clog2(N);
    localparam int PW = 2 * DATA_W;
    localparam int FW = $clog2(2 * N);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [K_W-1:0] k_len_q, k_cnt_q;
    logic           signed_q, sat_q, ovf_q;
    logic [FW-1:0]  flush_q;
    logic [RW-1:0]  row_q;
    logic [31:0]    cyc_q, mac_q;
    logic [N*N-1:0] pe_ovf;
    logic           start_acc, step_acc, row_acc;

    assign start_acc = (state_q == S_IDLE) && start;
    assign step_acc  = (state_q == S_FEED) && a_valid && b_valid;
    assign row_acc   = (state_q == S_DRAIN) && r_ready;

    always_comb begin
        state_d = state_q;
        a_ready = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        r_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = (k_len == '0) ? S_DRAIN : S_FEED;
            end
            S_FEED: begin
                a_ready = 1'b1;
                if (a_valid && b_valid && (k_cnt_q + K_W'(1) == k_len_q)) state_d = S_FLUSH;
            end
            S_FLUSH: if (flush_q == FW'(2 * N - 2)) state_d = S_DRAIN;
            S_DRAIN: begin
                r_valid = 1'b1;
                if (r_ready && row_q == RW'(N - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign b_ready     = a_ready;
    assign r_row       = row_q;
    assign r_last      = r_valid && (row_q == RW'(N - 1));
    assign overflow    = ovf_q;
    assign cycle_count = cyc_q;
    assign mac_count   = mac_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_len_q  <= '0;
            k_cnt_q  <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
            flush_q  <= '0;
            row_q    <= '0;
            cyc_q    <= '0;
            mac_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                k_len_q  <= k_len;
                signed_q <= signed_mode;
                sat_q    <= sat_en;
                k_cnt_q  <= '0;
                flush_q  <= '0;
                row_q    <= '0;
                ovf_q    <= 1'b0;
                cyc_q    <= 32'd1;
                mac_q    <= '0;
            end else begin
                if (busy) cyc_q <= cyc_q + 32'd1;
                if (step_acc) begin
                    k_cnt_q <= k_cnt_q + K_W'(1);
                    mac_q   <= mac_q + 32'(N * N);
                end
                if (state_q == S_FLUSH) flush_q <= flush_q + FW'(1);
                if (row_acc) row_q <= (row_q == RW'(N - 1)) ? '0 : row_q + RW'(1);
                if (|pe_ovf) ovf_q <= 1'b1;
            end
        end
    end

    // Operands travel as {valid, data}; lane i is delayed i cycles before column/row 0.
    logic [DATA_W:0] a_in [N];
    logic [DATA_W:0] b_in [N];

    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DATA_W:0] a_new, b_new;
        assign a_new = step_acc ? {1'b1, a_data[i*DATA_W +: DATA_W]} : '0;
        assign b_new = step_acc ? {1'b1, b_data[i*DATA_W +: DATA_W]} : '0;
        if (i == 0) begin : g_direct
            assign a_in[i] = a_new;
            assign b_in[i] = b_new;
        end else begin : g_pipe
            logic [DATA_W:0] a_pipe_q [i];
            logic [DATA_W:0] b_pipe_q [i];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) begin
                        a_pipe_q[s] <= '0;
                        b_pipe_q[s] <= '0;
                    end
                end else begin
                    a_pipe_q[0] <= a_new;
                    b_pipe_q[0] <= b_new;
                    for (int s = 1; s < i; s++) begin
                        a_pipe_q[s] <= a_pipe_q[s-1];
                        b_pipe_q[s] <= b_pipe_q[s-1];
                    end
                end
            end
            assign a_in[i] = a_pipe_q[i-1];
            assign b_in[i] = b_pipe_q[i-1];
        end
    end

    logic [DATA_W:0]  a_op  [N][N];
    logic [DATA_W:0]  b_op  [N][N];
    logic [ACC_W-1:0] acc_w [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_op[i][j] = a_in[i];
            end else begin : g_a_hop
                logic [DATA_W:0] a_hop_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) a_hop_q <= '0;
                    else        a_hop_q <= a_op[i][j-1];
                end
                assign a_op[i][j] = a_hop_q;
            end
            if (i == 0) begin : g_b_edge
                assign b_op[i][j] = b_in[j];
            end else begin : g_b_hop
                logic [DATA_W:0] b_hop_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) b_hop_q <= '0;
                    else        b_hop_q <= b_op[i-1][j];
                end
                assign b_op[i][j] = b_hop_q;
            end

            logic [PW-1:0]    a_x, b_x, prod;
            logic [ACC_W-1:0] ext, acc_q, acc_d;
            logic [ACC_W:0]   sum;
            logic             fire, ovf;

            assign fire = a_op[i][j][DATA_W] && b_op[i][j][DATA_W];

            // Low PW bits of the extended product are exact for both signed and unsigned.
            always_comb begin
                a_x = signed_q ? {{DATA_W{a_op[i][j][DATA_W-1]}}, a_op[i][j][DATA_W-1:0]}
                               : {{DATA_W{1'b0}}, a_op[i][j][DATA_W-1:0]};
                b_x = signed_q ? {{DATA_W{b_op[i][j][DATA_W-1]}}, b_op[i][j][DATA_W-1:0]}
                               : {{DATA_W{1'b0}}, b_op[i][j][DATA_W-1:0]};
                prod = a_x * b_x;
                if (signed_q) ext = ACC_W'($signed(prod));
                else          ext = ACC_W'(prod);
                if (signed_q) begin
                    sum = {acc_q[ACC_W-1], acc_q} + {ext[ACC_W-1], ext};
                    ovf = sum[ACC_W] != sum[ACC_W-1];
                end else begin
                    sum = {1'b0, acc_q} + {1'b0, ext};
                    ovf = sum[ACC_W];
                end
                acc_d = sum[ACC_W-1:0];
                if (ovf && sat_q) begin
                    if (!signed_q)    acc_d = '1;
                    else if (sum[ACC_W]) acc_d = {1'b1, {(ACC_W-1){1'b0}}};
                    else              acc_d = {1'b0, {(ACC_W-1){1'b1}}};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n || start_acc) acc_q <= '0;
                else if (fire)           acc_q <= acc_d;
            end

            assign pe_ovf[i*N+j] = fire && ovf;
            assign acc_w[i][j]   = acc_q;
        end
    end

    always_comb begin
        r_data = '0;
        if (state_q == S_DRAIN) begin
            for (int j = 0; j < N; j++) r_data[j*ACC_W +: ACC_W] = acc_w[row_q][j];
        end
    end
endmodule
